// File: rtl/stream_demux_nch.sv
// ============================================================================
// stream_demux_nch
//
// Registered 1-to-N stream demultiplexer with valid/ready flow control on the
// input and on every output channel. Each accepted input word is steered to
// the channel named by in_sel, or to every channel when in_bcast is set.
// Every channel owns a one-word output register, so a slot can be drained
// and reloaded in the same cycle. A word whose in_sel is out of range is
// accepted, discarded and counted in a saturating drop counter.
//
// Parameters
//   DATA_W  width of one data word
//   NUM_CH  number of output channels (2..16)
//   SEL_W   select width, at least $clog2(NUM_CH)
//   CNT_W   width of the drop counter
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears slots and drop counter)
//   in_data    input word
//   in_sel     destination channel for unicast
//   in_bcast   1: send to all channels, in_sel ignored
//   in_valid   input word/sel/bcast are valid
//   in_ready   input accepted this cycle (combinational, never from in_valid)
//   out_data   channel i at bits [i*DATA_W +: DATA_W]
//   out_valid  per-channel valid
//   out_ready  per-channel ready from the consumers
//   drop_cnt   saturating count of out-of-range words
// ============================================================================
module stream_demux_nch #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH),
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_bcast,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [CNT_W-1:0]         drop_cnt
);

   // One extra bit so NUM_CH itself is representable when SEL_W is minimal.
   localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

   // Saturating increment: the drop counter sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [NUM_CH-1:0] vld_p1;
   logic [DATA_W-1:0] data_p1 [NUM_CH];
   logic [CNT_W-1:0]  drop_cnt_p1;

   logic [NUM_CH-1:0] can_acc;
   logic [NUM_CH-1:0] sel_hit;
   logic [NUM_CH-1:0] load;
   logic              sel_ok;
   logic              xfer;
   logic              drop;

   // ---- stage p0: steering and handshake decision (combinational) ----
   always_comb begin
      sel_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel_hit[i] = ({1'b0, in_sel} == (SEL_W+1)'(i));
      end
   end

   // A slot can take a word if it is empty or is being drained this cycle.
   assign can_acc = ~vld_p1 | out_ready;
   assign sel_ok  = ({1'b0, in_sel} < NUM_CH_L);

   always_comb begin
      in_ready = 1'b1;
      if (in_bcast) begin
         in_ready = &can_acc;
      end else if (sel_ok) begin
         in_ready = |(sel_hit & can_acc);
      end
   end

   assign xfer = in_valid & in_ready;
   assign drop = xfer & ~in_bcast & ~sel_ok;

   always_comb begin
      load = '0;
      if (xfer) begin
         load = in_bcast ? {NUM_CH{1'b1}} : sel_hit;
      end
   end

   // ---- stage p1: per-channel output slots ----
   for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_p1[g]  <= 1'b0;
            data_p1[g] <= '0;
         end else begin
            if (load[g]) begin
               vld_p1[g]  <= 1'b1;
               data_p1[g] <= in_data;
            end else if (out_ready[g]) begin
               vld_p1[g]  <= 1'b0;
            end
         end
      end

      assign out_data[g*DATA_W +: DATA_W] = data_p1[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_p1 <= '0;
      end else if (drop) begin
         drop_cnt_p1 <= sat_inc(drop_cnt_p1);
      end
   end

   assign out_valid = vld_p1;
   assign drop_cnt  = drop_cnt_p1;

endmodule

// File: tb/tb_stream_demux_nch.sv
// Directed and randomised bench for stream_demux_nch. Three instances:
//   a: default 4 channels x 8 bits
//   b: 3 channels, SEL_W=2, 2-bit drop counter (out-of-range and saturation)
//   c: 5 channels x 12 bits, SEL_W=3 (random soak against a queue model)
module tb_stream_demux_nch;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- instance a ----------------
   logic [7:0]  a_in_data = '0;
   logic [1:0]  a_sel = '0;
   logic        a_bcast = 1'b0, a_valid = 1'b0, a_ready;
   logic [31:0] a_out_data;
   logic [3:0]  a_out_valid;
   logic [3:0]  a_out_ready = '0;
   logic [15:0] a_drop;

   stream_demux_nch #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_sel),
      .in_bcast(a_bcast), .in_valid(a_valid), .in_ready(a_ready),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .drop_cnt(a_drop));

   // ---------------- instance b ----------------
   logic [7:0]  b_in_data = '0;
   logic [1:0]  b_sel = '0;
   logic        b_bcast = 1'b0, b_valid = 1'b0, b_ready;
   logic [23:0] b_out_data;
   logic [2:0]  b_out_valid;
   logic [2:0]  b_out_ready = '0;
   logic [1:0]  b_drop;

   stream_demux_nch #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_sel),
      .in_bcast(b_bcast), .in_valid(b_valid), .in_ready(b_ready),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .drop_cnt(b_drop));

   // ---------------- instance c ----------------
   logic [11:0] c_in_data = '0;
   logic [2:0]  c_sel = '0;
   logic        c_bcast = 1'b0, c_valid = 1'b0, c_ready;
   logic [59:0] c_out_data;
   logic [4:0]  c_out_valid;
   logic [4:0]  c_out_ready = '0;
   logic [15:0] c_drop;

   stream_demux_nch #(.DATA_W(12), .NUM_CH(5), .SEL_W(3), .CNT_W(16)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_sel(c_sel),
      .in_bcast(c_bcast), .in_valid(c_valid), .in_ready(c_ready),
      .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .drop_cnt(c_drop));

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [11:0] mq [5][$];
   int          drops_m;
   bit          hold;
   logic [4:0]  can_m;
   logic        rdy_m;
   logic [4:0]  vld_m;

   initial begin
      // ---------------- reset state ----------------
      #2;
      check("rst_valid", a_out_valid, 4'b0000);
      check("rst_data", a_out_data, 32'h0);
      check("rst_drop", a_drop, 16'h0);
      check("rst_ready", a_ready, 1'b1);
      #5 rst_n = 1'b1;
      tick();

      // ---------------- sequential fill ----------------
      a_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a_sel     = 2'(k);
         a_in_data = 8'(8'h11 * (k + 1));
         #1 check("fill_ready", a_ready, 1'b1);
         tick();
      end
      a_valid = 1'b0;
      check("fill_valid", a_out_valid, 4'b1111);
      check("fill_data", a_out_data, 32'h44332211);

      a_valid = 1'b1; a_sel = 2'd2; a_in_data = 8'h99;
      #1 check("full_ready", a_ready, 1'b0);
      tick();
      a_valid = 1'b0;
      check("full_data", a_out_data, 32'h44332211);

      // ---------------- pass-through under back-pressure ----------------
      a_out_ready = 4'b0010;
      a_valid = 1'b1; a_sel = 2'd1; a_in_data = 8'hA5;
      #1 check("pt_ready", a_ready, 1'b1);
      tick();
      a_valid = 1'b0; a_out_ready = 4'b0000;
      check("pt_valid", a_out_valid, 4'b1111);
      check("pt_data", a_out_data, 32'h4433A511);

      // ---------------- broadcast all-or-nothing ----------------
      a_out_ready = 4'b0111;
      tick();
      a_out_ready = 4'b0000;
      check("drain_valid", a_out_valid, 4'b1000);
      check("drain_hold", a_out_data, 32'h4433A511);

      a_valid = 1'b1; a_bcast = 1'b1; a_in_data = 8'h5A;
      #1 check("bc_blk_ready", a_ready, 1'b0);
      tick();
      check("bc_blk_valid", a_out_valid, 4'b1000);
      check("bc_blk_data", a_out_data, 32'h4433A511);
      a_out_ready = 4'b1000;
      #1 check("bc_ready", a_ready, 1'b1);
      tick();
      a_valid = 1'b0; a_bcast = 1'b0; a_out_ready = 4'b0000;
      check("bc_valid", a_out_valid, 4'b1111);
      check("bc_data", a_out_data, 32'h5A5A5A5A);

      // ---------------- reset mid-operation (instance b) ----------------
      b_valid = 1'b1;
      b_sel = 2'd0; b_in_data = 8'h10; tick();
      b_sel = 2'd1; b_in_data = 8'h20; tick();
      b_sel = 2'd3; b_in_data = 8'hEE;
      for (int k = 0; k < 2; k++) begin
         #1 check("b_drop_ready", b_ready, 1'b1);
         tick();
      end
      b_valid = 1'b0;
      check("b_pre_valid", b_out_valid, 3'b011);
      check("b_pre_data", b_out_data, 24'h002010);
      check("b_pre_drop", b_drop, 2'd2);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", b_out_valid, 3'b000);
      check("mid_rst_data", b_out_data, 24'h0);
      check("mid_rst_drop", b_drop, 2'd0);
      check("mid_rst_a_valid", a_out_valid, 4'b0000);
      #2 rst_n = 1'b1;
      tick();

      // ---------------- out-of-range drops and saturation ----------------
      b_valid = 1'b1; b_sel = 2'd3; b_in_data = 8'h77;
      for (int k = 1; k <= 5; k++) begin
         #1 check("oor_ready", b_ready, 1'b1);
         tick();
         check("oor_drop", b_drop, (k > 3) ? 2'd3 : 2'(k));
      end
      b_valid = 1'b0;
      check("oor_valid", b_out_valid, 3'b000);

      // ---------------- random soak (instance c) ----------------
      drops_m = 0;
      hold = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(posedge clk);
         #1;
         if (!hold) begin
            c_valid   = 1'($urandom_range(0, 1));
            c_sel     = 3'($urandom_range(0, 7));
            c_bcast   = ($urandom_range(0, 7) == 0);
            c_in_data = 12'($urandom_range(0, 4095));
         end
         c_out_ready = 5'($urandom);
         @(negedge clk);
         for (int i = 0; i < 5; i++) begin
            can_m[i] = (mq[i].size() == 0) || c_out_ready[i];
            vld_m[i] = (mq[i].size() != 0);
         end
         if (c_bcast)      rdy_m = &can_m;
         else if (c_sel < 5) rdy_m = can_m[c_sel];
         else              rdy_m = 1'b1;
         check("soak_ready", c_ready, rdy_m);
         check("soak_valid", c_out_valid, vld_m);
         check("soak_drop", c_drop, 16'(drops_m));
         for (int i = 0; i < 5; i++) begin
            if (mq[i].size() != 0) begin
               check("soak_data", c_out_data[i*12 +: 12], mq[i][0]);
               if (c_out_ready[i]) void'(mq[i].pop_front());
            end
         end
         if (c_valid && rdy_m) begin
            if (c_bcast) begin
               for (int i = 0; i < 5; i++) mq[i].push_back(c_in_data);
            end else if (c_sel < 5) begin
               mq[c_sel].push_back(c_in_data);
            end else begin
               drops_m++;
            end
         end
         hold = c_valid && !rdy_m;
      end
      c_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stream_demux_nch.md
# stream_demux_nch

Registered, parametrised 1-to-N stream demultiplexer with valid/ready flow control on the input and on every output channel. Each input word is steered to one channel by `in_sel`, or to all channels in broadcast mode. Each channel has a one-word output register. Words with an out-of-range select are dropped and counted. The block sits between a single producer and up to N independent consumers, and replaces the fixed 4-way combinational demux wherever back-pressure or registered outputs are needed.

## Interface
- `DATA_W`, default 8: width of one data word.
- `NUM_CH`, default 4: number of output channels; legal range 2..16.
- `SEL_W`, default `$clog2(NUM_CH)`: select width; must be at least `$clog2(NUM_CH)`.
- `CNT_W`, default 16: width of the drop counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in `DATA_W`: input word.
- `in_sel` in `SEL_W`: destination channel index (unicast).
- `in_bcast` in 1: 1 sends the word to all channels and ignores `in_sel`.
- `in_valid` in 1: input word, sel and bcast are valid.
- `in_ready` out 1: block accepts the input this cycle.
- `out_data` out `NUM_CH*DATA_W`: channel i occupies bits `[i*DATA_W +: DATA_W]`.
- `out_valid` out `NUM_CH`: per-channel valid.
- `out_ready` in `NUM_CH`: per-channel ready from the consumer.
- `drop_cnt` out `CNT_W`: count of dropped words; saturates.

## Operation
- Per-channel slot: one `DATA_W` register plus a valid bit.
- `can_acc[i] = !out_valid[i] || out_ready[i]`, so a slot may load in the same cycle it is drained.
- Accept condition: a transfer occurs when `in_valid && in_ready`.
- Unicast, `in_bcast=0`, `in_sel < NUM_CH`:
  - `in_ready = can_acc[in_sel]`.
  - On transfer, slot `in_sel` loads `in_data` and sets valid.
  - No other slot is disturbed.
- Unicast, `in_sel >= NUM_CH`:
  - `in_ready = 1`.
  - On transfer, the word is discarded and `drop_cnt` increments.
  - `drop_cnt` saturates at all-ones and never wraps.
- Broadcast, `in_bcast=1`:
  - `in_ready = &can_acc`, all-or-nothing.
  - On transfer, every slot loads `in_data` and sets valid.
  - A partial broadcast is never performed.
- Slot drain: `out_valid[i] && out_ready[i]` with no simultaneous load clears valid. Drain and load in the same cycle keep valid=1 with the new data.
- `out_data[i]` holds its last loaded value when valid is 0. It changes only on a load of that slot.
- `in_ready` is combinational from `in_sel`, `in_bcast` and `out_ready`. It does not depend on `in_valid`.
- The producer must hold `in_data`, `in_sel` and `in_bcast` stable while `in_valid=1 && in_ready=0`.
- `out_valid[i]` stays asserted until its handshake completes. `out_data[i]` is stable while valid and not ready.
- Reset, asserted at any time, including mid-transfer:
  - All `out_valid = 0`, all `out_data = 0`, `drop_cnt = 0`.
  - `in_ready` then evaluates per the rules above; it is 1 for any legal sel, because all slots are empty.
  - Words held in slots are lost.

## Timing
- Latency: an input accepted at edge k gives `out_valid[i]=1` after edge k, visible in cycle k+1.
- Throughput: one word per cycle per channel while that channel's `out_ready` is held high.
- Independent channels can drain concurrently. Only one input word is accepted per cycle.
- No combinational path from `in_valid` or `in_data` to any output.
- One combinational path exists from `out_ready` to `in_ready`.
- `drop_cnt` updates at the edge of the dropping transfer.

## Test plan
- Reset and sequential fill:
  - Stimulus: release reset, all `out_ready=0`; send 0x11, 0x22, 0x33, 0x44 to sel 0..3 on consecutive cycles.
  - Response: each `in_ready=1`; after 4 edges `out_valid=4'b1111` and channel data 0x11..0x44.
  - Then a fifth word to sel 2 sees `in_ready=0`.
- Back-pressure with pass-through:
  - Stimulus: channel 1 full and `out_ready[1]=1`; send 0xA5 to sel 1.
  - Response: accepted in the same cycle; `out_valid[1]` stays 1; `out_data[1]` becomes 0xA5 next cycle.
- Broadcast all-or-nothing:
  - Stimulus: channel 3 full with `out_ready[3]=0`; broadcast 0x5A.
  - Response: `in_ready=0`; no slot changes.
  - Stimulus: raise `out_ready[3]`.
  - Response: transfer; all four channels show 0x5A and `out_valid=4'b1111`.
- Out-of-range select:
  - Stimulus: `NUM_CH=3`, `SEL_W=2`; send 3 words with `in_sel=3`.
  - Response: `in_ready=1`; no `out_valid` change; `drop_cnt` reads 3.
  - Stimulus: `CNT_W=2` with a 5th drop.
  - Response: `drop_cnt` holds 3.
- Reset mid-operation:
  - Stimulus: with slots valid and `drop_cnt=2`, pulse `rst_n` low between edges.
  - Response: outputs clear immediately, without waiting for a clock edge.
- Random soak:
  - Stimulus: 10k cycles of random valid, sel, bcast and `out_ready`, with `NUM_CH=5` and `DATA_W=12`.
  - Response: the scoreboard sees per-channel order preserved, no loss or duplication, and a drop count matching the model.
